eprisc_spi_v2: RTL and testbench
================================

EPRISC_SPI_V2 -- requirements
Module: eprisc_spi_v2

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, frame length in bits (legal range 4..16).
REQ-002 SHALL provide parameter SS_N, default 4, number of slave selects (legal range 1..8).
REQ-003 SHALL provide parameter DIV_W, default 8, divider register width (legal range 1..16).
REQ-004 iClk  in  1  system clock; all logic in this single domain.
REQ-005 iRst  in  1  reset, asynchronous, active-high.
REQ-006 iAddr  in  2  register select: 0 CTRL, 1 TX, 2 RX, 3 DIV.
REQ-007 iData  in  16  write data.
REQ-008 iWrite  in  1  write strobe, qualified by iEnable.
REQ-009 iEnable  in  1  block select.
REQ-010 oData  out  16  read data; 0 when iEnable low.
REQ-011 oInt  out  1  interrupt, level, equal to CTRL.done AND CTRL.ie.
REQ-012 iMISO  in  1  serial in.
REQ-013 oMOSI  out  1  serial out.
REQ-014 oSCLK  out  1  serial clock.
REQ-015 oSS  out  SS_N  slave selects, active-low.

Function
REQ-016 CTRL bits SHALL be: [0] CPOL, [1] CPHA, [2] LSB-first, [3] ie, [4] hold-SS, [5] overrun (read; write 1 clears), [6] done (read; write 1 clears), [7] start/busy, [15:8] one-hot SS select (bits beyond SS_N read 0).
REQ-017 Writing CTRL with bit7=1 while idle SHALL start a transfer; busy SHALL read 1 on the cycle after the write.
REQ-018 Writes to CTRL (except bits 5/6 clear), TX, or DIV while busy SHALL be ignored.
REQ-019 FSM states SHALL be IDLE -> SETUP -> SHIFT -> HOLD -> IDLE; each half-period lasts DIV+1 iClk cycles.
REQ-020 SETUP: oSS asserted per CTRL[15:8], oSCLK=CPOL, first bit driven on oMOSI; duration one half-period.
REQ-021 SHIFT: 2*DATA_W half-periods; oSCLK toggles at each half-period boundary.
REQ-022 CPHA=0: sample iMISO on leading edge, change oMOSI on trailing edge; CPHA=1: change on leading, sample on trailing.
REQ-023 Bit order SHALL be MSB-first (TX[DATA_W-1] first) unless LSB-first set; RX assembled in the same order.
REQ-024 HOLD: one half-period, oSCLK=CPOL; then oSS deasserted unless hold-SS set.
REQ-025 Total start-to-busy-clear time SHALL be (2*DATA_W+2)*(DIV+1) iClk cycles.
REQ-026 On entering IDLE the received word SHALL be written to RX (zero-extended to 16), done set, busy cleared, same cycle.
REQ-027 Completion coincident with an RX read SHALL leave new data in RX and done set.
REQ-028 oMOSI SHALL be 1 and oSCLK SHALL equal CPOL whenever idle.
REQ-029 DIV=0 SHALL give oSCLK = iClk/2.

Reset
REQ-030 iRst SHALL force IDLE immediately, including mid-transfer, with no completion or done set.
REQ-031 Reset values: CTRL=0, TX=0, RX=0, DIV=0, oSS all 1, oSCLK=0, oMOSI=1, oInt=0, oData=0.

Configuration
REQ-032 Macro SPI_RXFIFO_EN defined: RX SHALL be a 4-entry FIFO; reading RX pops; done = FIFO non-empty; completion with FIFO full SHALL drop the word and set overrun; read of empty FIFO returns 0.
REQ-033 Macro SPI_RXFIFO_EN undefined: RX SHALL be a single register; completion while done already set SHALL overwrite RX and set overrun; reading RX SHALL clear done.

Verification
REQ-034 DIV=0, mode 0, TX=0xA5, SS=0x01, MISO looped to MOSI -> MOSI 1,0,1,0,0,1,0,1; RX=0x00A5; busy clear after 18 cycles.
REQ-035 Mode 3, DIV=3, LSB-first, TX=0x01 -> SCLK idle high, period 8 cycles, first MOSI bit 1, done at cycle 72.
REQ-036 ie=1, transfer completes -> oInt=1; write CTRL bit6=1 -> oInt=0 next cycle.
REQ-037 Start, then write TX=0xFF and DIV=5 mid-transfer -> both ignored, transfer unchanged.
REQ-038 Assert iRst at bit 3 of SHIFT -> oSS=all 1, oSCLK=0, done=0 immediately.
REQ-039 Without SPI_RXFIFO_EN: two transfers, no RX read -> overrun=1, RX holds second word; with SPI_RXFIFO_EN: five transfers -> four words popped in order, overrun=1.

Source files
------------

// File: rtl/eprisc_spi_v2.sv
// eprisc_spi_v2: register-mapped SPI master (CTRL/TX/RX/DIV) with programmable mode, bit order and clock divider.
// Optional macro SPI_RXFIFO_EN turns RX into a 4-entry FIFO; otherwise RX is a single register.
module eprisc_spi_v2 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SS_N   = 4,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [1:0]        iAddr,
    input  logic [15:0]       iData,
    input  logic              iWrite,
    input  logic              iEnable,
    output logic [15:0]       oData,
    output logic              oInt,
    input  logic              iMISO,
    output logic              oMOSI,
    output logic              oSCLK,
    output logic [SS_N-1:0]   oSS
);

    localparam int unsigned HALF_W = 6;
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_TX   = 2'd1;
    localparam logic [1:0] A_RX   = 2'd2;
    localparam logic [1:0] A_DIV  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t state_q, state_d;

    logic              cpol_q, cpha_q, lsb_q, ie_q, hold_q, ovr_q;
    logic [SS_N-1:0]   ss_sel_q;
    logic [DATA_W-1:0] tx_q;
    logic [DIV_W-1:0]  div_q;

    logic [DIV_W-1:0]  cnt_q;
    logic [HALF_W-1:0] half_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] rxs_q;
    logic              sclk_q, mosi_q;
    logic [SS_N-1:0]   ss_q;

    logic              idle, tick;
    logic              wr_c, rx_rd_c, ctrl_wr_c, cfg_wr_c, start_wr_c;
    logic              edge_v, complete;
    logic [HALF_W-1:0] edge_idx;
    logic              sample_c, shift_c;
    logic              done_c, ovr_set_c;
    logic [DATA_W-1:0] rx_head_c;
    logic              unused_bits;

    // Bus decode; config writes only land while idle, W1C bits always land.
    assign idle       = (state_q == ST_IDLE);
    assign tick       = (cnt_q == div_q);
    assign wr_c       = iEnable & iWrite;
    assign rx_rd_c    = iEnable & ~iWrite & (iAddr == A_RX);
    assign ctrl_wr_c  = wr_c & (iAddr == A_CTRL);
    assign cfg_wr_c   = ctrl_wr_c & idle;
    assign start_wr_c = cfg_wr_c & iData[7];
    assign unused_bits = ^iData;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state plus SCLK edge bookkeeping; edge_idx is the SHIFT half-period being entered.
    always_comb begin
        state_d  = state_q;
        edge_v   = 1'b0;
        edge_idx = '0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE:  if (start_wr_c) state_d = ST_SETUP;
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    edge_v  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (half_q == LAST_HALF) begin
                        state_d = ST_HOLD;
                    end else begin
                        edge_v   = 1'b1;
                        edge_idx = half_q + HALF_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d  = ST_IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Even edge index = leading edge. The first bit is already on MOSI from SETUP.
    assign sample_c = edge_v & (cpha_q ? edge_idx[0] : ~edge_idx[0]);
    assign shift_c  = edge_v & (cpha_q ? (~edge_idx[0] & (edge_idx != '0))
                                       : (edge_idx[0] & (edge_idx != LAST_HALF)));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            ie_q     <= 1'b0;
            hold_q   <= 1'b0;
            ss_sel_q <= '0;
            tx_q     <= '0;
            div_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (cfg_wr_c) begin
                cpol_q   <= iData[0];
                cpha_q   <= iData[1];
                lsb_q    <= iData[2];
                ie_q     <= iData[3];
                hold_q   <= iData[4];
                ss_sel_q <= iData[8 +: SS_N];
            end
            if (wr_c && idle && iAddr == A_TX)  tx_q  <= iData[DATA_W-1:0];
            if (wr_c && idle && iAddr == A_DIV) div_q <= iData[DIV_W-1:0];
            if (ovr_set_c)                      ovr_q <= 1'b1;
            else if (ctrl_wr_c && iData[5])     ovr_q <= 1'b0;
        end
    end

    // Divider, half-period counter, shifters and registered serial pins.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q  <= '0;
            half_q <= '0;
            sh_q   <= '0;
            rxs_q  <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b1;
            ss_q   <= '1;
        end else begin
            cnt_q <= (idle || tick) ? '0 : cnt_q + DIV_W'(1);
            if (state_q == ST_SETUP && tick)
                half_q <= '0;
            else if (state_q == ST_SHIFT && tick)
                half_q <= half_q + HALF_W'(1);

            if (start_wr_c) begin
                sh_q   <= tx_q;
                rxs_q  <= '0;
                mosi_q <= iData[2] ? tx_q[0] : tx_q[DATA_W-1];
                sclk_q <= iData[0];
                ss_q   <= ~iData[8 +: SS_N];
            end else if (complete) begin
                sclk_q <= cpol_q;
                mosi_q <= 1'b1;
                if (!hold_q) ss_q <= '1;
            end else if (idle) begin
                sclk_q <= cfg_wr_c ? iData[0] : cpol_q;
                mosi_q <= 1'b1;
                if (!(cfg_wr_c ? iData[4] : hold_q)) ss_q <= '1;
            end else begin
                if (edge_v) sclk_q <= ~sclk_q;
                if (shift_c) begin
                    sh_q   <= lsb_q ? (sh_q >> 1) : (sh_q << 1);
                    mosi_q <= lsb_q ? sh_q[1] : sh_q[DATA_W-2];
                end
                if (sample_c)
                    rxs_q <= lsb_q ? {iMISO, rxs_q[DATA_W-1:1]} : {rxs_q[DATA_W-2:0], iMISO};
            end
        end
    end

`ifdef SPI_RXFIFO_EN
    localparam int unsigned FIFO_D = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;

    logic [DATA_W-1:0] mem_q [FIFO_D];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              pop_c, push_c, flush_c;

    // Writing done=1 flushes the FIFO; a completing word in that cycle still lands.
    assign flush_c   = ctrl_wr_c & iData[6];
    assign pop_c     = rx_rd_c & (count_q != '0) & ~flush_c;
    assign push_c    = complete & (flush_c | pop_c | (count_q != CNT_W'(FIFO_D)));
    assign ovr_set_c = complete & ~push_c;
    assign done_c    = (count_q != '0);
    assign rx_head_c = done_c ? mem_q[rptr_q] : '0;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
        end else begin
            if (push_c) begin
                mem_q[wptr_q] <= rxs_q;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (flush_c) begin
                rptr_q  <= wptr_q;
                count_q <= push_c ? CNT_W'(1) : '0;
            end else begin
                if (pop_c) rptr_q <= rptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            end
        end
    end
`else
    logic              done_q;
    logic [DATA_W-1:0] rx_q;

    assign ovr_set_c = complete & done_q;
    assign done_c    = done_q;
    assign rx_head_c = rx_q;

    // Completion wins over a same-cycle RX read or done clear.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            done_q <= 1'b0;
            rx_q   <= '0;
        end else begin
            if (complete) begin
                done_q <= 1'b1;
                rx_q   <= rxs_q;
            end else if ((ctrl_wr_c && iData[6]) || rx_rd_c) begin
                done_q <= 1'b0;
            end
        end
    end
`endif

    // Read mux.
    always_comb begin
        oData = '0;
        if (iEnable) begin
            case (iAddr)
                A_CTRL: oData = {8'(ss_sel_q), ~idle, done_c, ovr_q, hold_q, ie_q, lsb_q, cpha_q, cpol_q};
                A_TX:   oData = 16'(tx_q);
                A_RX:   oData = 16'(rx_head_c);
                A_DIV:  oData = 16'(div_q);
                default: oData = '0;
            endcase
        end
    end

    assign oInt  = done_c & ie_q;
    assign oMOSI = mosi_q;
    assign oSCLK = sclk_q;
    assign oSS   = ss_q;

endmodule

// File: tb/tb_eprisc_spi_v2.sv
// Self-checking bench for eprisc_spi_v2: register access, SPI modes, timing, busy-write protection, reset and overrun.
module tb_eprisc_spi_v2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'd0;
    logic        wr = 1'b0;
    logic        en = 1'b0;
    logic [15:0] rdata;
    logic        irq;
    logic        miso;
    logic        mosi;
    logic        sclk;
    logic [3:0]  ss;
    logic        miso_inv = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [15:0] exp_q[$];
    logic        bits_q[$];
    int          lead_q[$];
    logic        mon_cpol = 1'b0;
    logic        mon_cpha = 1'b0;
    logic        sclk_prev = 1'b0;

    eprisc_spi_v2 dut (
        .iClk(clk), .iRst(rst), .iAddr(addr), .iData(wdata), .iWrite(wr), .iEnable(en),
        .oData(rdata), .oInt(irq), .iMISO(miso), .oMOSI(mosi), .oSCLK(sclk), .oSS(ss)
    );

    assign miso = mosi ^ miso_inv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record MOSI on sampling edges and the cycle of every leading edge.
    always @(posedge clk) begin
        #1;
        if (sclk !== sclk_prev) begin
            if ((sclk != mon_cpol) ^ mon_cpha) bits_q.push_back(mosi);
            if (sclk != mon_cpol) lead_q.push_back(cyc);
        end
        sclk_prev <= sclk;
    end

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = a;
        #1 d = rdata;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] ctrl);
        bits_q.delete();
        lead_q.delete();
        mon_cpol = ctrl[0];
        mon_cpha = ctrl[1];
        bus_wr(2'd0, ctrl);
        start_cyc = cyc;
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        en = 1'b1; wr = 1'b0; addr = 2'd0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            if (!rdata[7]) begin
                cycles = cyc - start_cyc;
                break;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ss !== 4'hF)  begin errors++; $display("FAIL reset_ss: got %h want f", ss); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b want 1", mosi); end
        checks++; if (irq !== 1'b0)  begin errors++; $display("FAIL reset_int: got %b want 0", irq); end
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_odata: got %h want 0", rdata); end
        @(negedge clk); rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_rd(2'(a), d);
            checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_mode0();
        logic [15:0] d, e;
        logic [7:0]  got;
        int          cycles;
        miso_inv = 1'b0;
        bus_wr(2'd3, 16'd0);
        bus_wr(2'd1, 16'h00A5);
        exp_q.push_back(16'h00A5);
        start_xfer(16'h0180);
        checks++; if (ss !== 4'b1110) begin errors++; $display("FAIL m0_ss: got %h want e", ss); end
        wait_done(cycles);
        checks++; if (cycles != 18) begin errors++; $display("FAIL m0_cycles: got %0d want 18", cycles); end
        got = 8'h00;
        foreach (bits_q[i]) got = {got[6:0], bits_q[i]};
        checks++; if (bits_q.size() != 8 || got !== 8'hA5)
            begin errors++; $display("FAIL m0_mosi_bits: got %h (%0d bits) want a5 (8 bits)", got, bits_q.size()); end
        bus_rd(2'd0, d);
        checks++; if (d !== 16'h0140) begin errors++; $display("FAIL m0_ctrl: got %h want 0140", d); end
        bus_rd(2'd2, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL m0_rx: got %h want %h", d, e); end
        checks++; if (ss !== 4'hF) begin errors++; $display("FAIL m0_ss_idle: got %h want f", ss); end
    endtask

    task automatic test_mode3();
        logic [15:0] d, e;
        int          cycles;
        miso_inv = 1'b0;
        bus_wr(2'd3, 16'd3);
        bus_wr(2'd1, 16'h0001);
        bus_wr(2'd0, 16'h0207);
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle: got %b want 1", sclk); end
        exp_q.push_back(16'h0001);
        start_xfer(16'h0287);
        checks++; if (ss !== 4'b1101) begin errors++; $display("FAIL m3_ss: got %h want d", ss); end
        wait_done(cycles);
        checks++; if (cycles != 72) begin errors++; $display("FAIL m3_cycles: got %0d want 72", cycles); end
        checks++; if (lead_q.size() != 8 || (lead_q[1] - lead_q[0]) != 8)
            begin errors++; $display("FAIL m3_period: got %0d edges want 8 edges period 8", lead_q.size()); end
        checks++; if (bits_q.size() == 0 || bits_q[0] !== 1'b1)
            begin errors++; $display("FAIL m3_first_bit: got %0d bits want first bit 1", bits_q.size()); end
        bus_rd(2'd2, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL m3_rx: got %h want %h", d, e); end
        bus_wr(2'd0, 16'h0000);
    endtask

    task automatic test_irq();
        int cycles;
        miso_inv = 1'b1;
        bus_wr(2'd3, 16'd1);
        bus_wr(2'd1, 16'h005A);
        start_xfer(16'h0188);
        wait_done(cycles);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
        bus_wr(2'd0, 16'h0048);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        miso_inv = 1'b0;
    endtask

    task automatic test_busy_writes();
        logic [15:0] d, e;
        int          cycles;
        bus_wr(2'd3, 16'd1);
        bus_wr(2'd1, 16'h003C);
        exp_q.push_back(16'h003C);
        start_xfer(16'h0180);
        bus_wr(2'd1, 16'h00FF);
        bus_wr(2'd3, 16'd5);
        bus_wr(2'd0, 16'h0F87);
        wait_done(cycles);
        checks++; if (cycles != 36) begin errors++; $display("FAIL busy_cycles: got %0d want 36", cycles); end
        bus_rd(2'd1, d);
        checks++; if (d !== 16'h003C) begin errors++; $display("FAIL busy_tx: got %h want 003c", d); end
        bus_rd(2'd3, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL busy_div: got %h want 0001", d); end
        bus_rd(2'd0, d);
        checks++; if (d !== 16'h0140) begin errors++; $display("FAIL busy_ctrl: got %h want 0140", d); end
        bus_rd(2'd2, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL busy_rx: got %h want %h", d, e); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        bus_wr(2'd3, 16'd0);
        bus_wr(2'd1, 16'h00C3);
        start_xfer(16'h0180);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        en = 1'b1; wr = 1'b0; addr = 2'd0;
        #1;
        checks++; if (ss !== 4'hF)  begin errors++; $display("FAIL rstmid_ss: got %h want f", ss); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b want 0", sclk); end
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL rstmid_ctrl: got %h want 0", rdata); end
        en = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (30) @(posedge clk);
        bus_rd(2'd0, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL rstmid_no_done: got %h want 0", d); end
    endtask

    task automatic test_overrun();
        logic [15:0] d, e;
        int          cycles;
        miso_inv = 1'b0;
        bus_wr(2'd3, 16'd0);
`ifdef SPI_RXFIFO_EN
        for (int n = 1; n <= 5; n++) begin
            bus_wr(2'd1, 16'(n * 16'h11));
            if (n <= 4) exp_q.push_back(16'(n * 16'h11));
            start_xfer(16'h0180);
            wait_done(cycles);
        end
        bus_rd(2'd0, d);
        checks++; if (d !== 16'h0160) begin errors++; $display("FAIL ovr_ctrl: got %h want 0160", d); end
        for (int n = 0; n < 4; n++) begin
            bus_rd(2'd2, d);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL ovr_rx%0d: got %h want %h", n, d, e); end
        end
        bus_rd(2'd2, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL ovr_empty: got %h want 0", d); end
`else
        bus_wr(2'd1, 16'h0011);
        start_xfer(16'h0180);
        wait_done(cycles);
        bus_wr(2'd1, 16'h0022);
        exp_q.push_back(16'h0022);
        start_xfer(16'h0180);
        wait_done(cycles);
        bus_rd(2'd0, d);
        checks++; if (d !== 16'h0160) begin errors++; $display("FAIL ovr_ctrl: got %h want 0160", d); end
        bus_rd(2'd2, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL ovr_rx: got %h want %h", d, e); end
`endif
        bus_wr(2'd0, 16'h0020);
        bus_rd(2'd0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ovr_clear: got %h want 0000", d); end
    endtask

    task automatic test_coincident();
        logic [15:0] d, e;
        miso_inv = 1'b1;
        bus_wr(2'd3, 16'd0);
        bus_wr(2'd1, 16'h0096);
        exp_q.push_back(16'h0069);
        start_xfer(16'h0180);
        repeat (17) @(posedge clk);
        bus_rd(2'd2, d);
        bus_rd(2'd0, d);
        checks++; if (d !== 16'h0140) begin errors++; $display("FAIL coin_ctrl: got %h want 0140", d); end
        bus_rd(2'd2, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL coin_rx: got %h want %h", d, e); end
        miso_inv = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, e;
        logic [7:0]  tx;
        logic [2:0]  mode;
        int          dv, cycles;
        for (int n = 0; n < 4; n++) begin
            tx   = 8'($urandom);
            mode = 3'($urandom);
            dv   = int'($urandom_range(0, 2));
            miso_inv = n[0];
            bus_wr(2'd3, 16'(dv));
            bus_wr(2'd1, 16'(tx));
            exp_q.push_back(16'(tx ^ {8{miso_inv}}));
            start_xfer(16'h0180 | 16'(mode));
            wait_done(cycles);
            checks++; if (cycles != 18 * (dv + 1))
                begin errors++; $display("FAIL b2b_cycles%0d: got %0d want %0d", n, cycles, 18 * (dv + 1)); end
            bus_rd(2'd2, d);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL b2b_rx%0d: got %h want %h", n, d, e); end
        end
        miso_inv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_irq();
        test_busy_writes();
        test_reset_mid();
        test_overrun();
        test_coincident();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
